// File: rtl/rcservo_multi_if.sv
// rcservo_multi_if: command/feedback/pulse bundle of the multi-channel servo driver.
// master = controller side (drives enables and step commands),
// slave  = servo driver side (returns position feedback, pulses and frame marker).
interface rcservo_multi_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0]    enable;
  logic [32*NUM_CH-1:0] jointFreqCmd;
  logic [32*NUM_CH-1:0] jointFeedback;
  logic [NUM_CH-1:0]    PWM;
  logic                 frame_start;

  modport master (
    output enable,
    output jointFreqCmd,
    input  jointFeedback,
    input  PWM,
    input  frame_start
  );

  modport slave (
    input  enable,
    input  jointFreqCmd,
    output jointFeedback,
    output PWM,
    output frame_start
  );
endinterface

// File: rtl/rcservo_multi.sv
// rcservo_multi: multi-channel RC servo driver.
// Each channel integrates a signed step-frequency command into a saturating
// position counter; the position maps to a clamped pulse width that is latched
// once per frame. All channels share one frame counter so pulses start together.
// Optional feature macro: RCSERVO_SLEW_EN -- when defined, the latched width moves
// toward its target by at most SLEW_MAX per frame.
module rcservo_multi #(
  parameter int NUM_CH       = 4,
  parameter int SERVO_PERIOD = 480000,
  parameter int SERVO_CENTER = 72000,
  parameter int PULSE_MIN    = 48000,
  parameter int PULSE_MAX    = 96000,
  parameter int SCALE_SHIFT  = 6,
  parameter int POS_LIMIT    = 2000000,
  parameter int SLEW_MAX     = 200
) (
  input logic           clk,
  input logic           rst,
  rcservo_multi_if.slave bus
);

  // Refuse to elaborate with limits that cannot produce a valid pulse.
  if (!(PULSE_MIN <= SERVO_CENTER && SERVO_CENTER <= PULSE_MAX &&
        PULSE_MAX < SERVO_PERIOD && SLEW_MAX >= 0)) begin : g_bad_params
    $error("rcservo_multi: inconsistent pulse/period parameters");
  end

  localparam logic [31:0] FRAME_LAST = 32'(SERVO_PERIOD - 1);

  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic        frame_start_q;
  logic        frame_last;

  // Next frame count: wrap to 0 after the last cycle of the frame.
  always_comb begin
    frame_last  = (frame_cnt_q == FRAME_LAST);
    frame_cnt_d = frame_last ? 32'd0 : frame_cnt_q + 32'd1;
  end

  // Shared frame counter and registered frame marker (aligned with PWM rising edges).
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q   <= 32'd0;
      frame_start_q <= 1'b0;
    end else begin
      frame_cnt_q   <= frame_cnt_d;
      frame_start_q <= (frame_cnt_q == 32'd0);
    end
  end

  assign bus.frame_start = frame_start_q;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic signed [31:0] cmd;
    logic        [31:0] mag;
    logic        [31:0] half;
    logic        [31:0] cnt_q, cnt_d;
    logic               phase_q, phase_d;
    logic signed [31:0] fb_q, fb_d;
    logic signed [31:0] fb_sh;
    logic signed [32:0] raw;
    logic        [31:0] target;
    logic        [31:0] width_q, width_d;
    logic               en_lat_q;
    logic               pwm_q;
`ifdef RCSERVO_SLEW_EN
    logic signed [31:0] diff;
`endif

    assign cmd = $signed(bus.jointFreqCmd[32*gi +: 32]);

    // Step generator, position feedback and frame-latched width target.
    always_comb begin
      // |cmd| with the most negative command saturating instead of wrapping.
      if (cmd[31]) begin
        mag = (cmd == 32'sh8000_0000) ? 32'h7FFF_FFFF : 32'(-cmd);
      end else begin
        mag = 32'(cmd);
      end
      half    = mag >> 1;
      cnt_d   = cnt_q;
      phase_d = phase_q;
      fb_d    = fb_q;
      if (bus.enable[gi] && cmd != 32'sd0) begin
        if (cnt_q >= half) begin
          cnt_d   = 32'd0;
          phase_d = ~phase_q;
          // A full step completes on the falling phase; steps past the limit are dropped.
          if (phase_q) begin
            if (!cmd[31] && fb_q < POS_LIMIT) begin
              fb_d = fb_q + 32'sd1;
            end else if (cmd[31] && fb_q > -POS_LIMIT) begin
              fb_d = fb_q - 32'sd1;
            end
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      // Width target from current position, in 33 bits so the offset cannot wrap.
      fb_sh = fb_q >>> SCALE_SHIFT;
      raw   = $signed(33'(SERVO_CENTER)) + $signed({fb_sh[31], fb_sh});
      if (raw < $signed(33'(PULSE_MIN))) begin
        target = 32'(PULSE_MIN);
      end else if (raw > $signed(33'(PULSE_MAX))) begin
        target = 32'(PULSE_MAX);
      end else begin
        target = raw[31:0];
      end

`ifdef RCSERVO_SLEW_EN
      // Approach the target by at most SLEW_MAX per frame.
      diff = $signed(target) - $signed(width_q);
      if (diff > SLEW_MAX) begin
        width_d = width_q + 32'(SLEW_MAX);
      end else if (diff < -SLEW_MAX) begin
        width_d = width_q - 32'(SLEW_MAX);
      end else begin
        width_d = target;
      end
`else
      width_d = target;
`endif
    end

    // Channel state; width/enable are only sampled on the last frame cycle so a pulse is never altered mid-frame.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q    <= 32'd0;
        phase_q  <= 1'b0;
        fb_q     <= 32'sd0;
        width_q  <= 32'(SERVO_CENTER);
        en_lat_q <= 1'b0;
        pwm_q    <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        phase_q <= phase_d;
        fb_q    <= fb_d;
        pwm_q   <= en_lat_q && (frame_cnt_q < width_q);
        if (frame_last) begin
          width_q  <= width_d;
          en_lat_q <= bus.enable[gi];
        end
      end
    end

    assign bus.jointFeedback[32*gi +: 32] = fb_q;
    assign bus.PWM[gi]                    = pwm_q;
  end

endmodule

// File: tb/tb_rcservo_multi.sv
// tb_rcservo_multi: directed bench for rcservo_multi with a per-cycle reference
// model plus hand-computed checkpoints (idle, stepping, saturation, frame
// atomicity, mid-frame reset). Works with or without RCSERVO_SLEW_EN.
module tb_rcservo_multi;
  localparam int NCH   = 2;
  localparam int P     = 1000;
  localparam int CTR   = 150;
  localparam int WMIN  = 100;
  localparam int WMAX  = 200;
  localparam int SHIFT = 2;
  localparam int LIM   = 1000;
  localparam int SLEW  = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rcservo_multi_if #(.NUM_CH(NCH)) bus_if ();

  rcservo_multi #(
    .NUM_CH(NCH), .SERVO_PERIOD(P), .SERVO_CENTER(CTR), .PULSE_MIN(WMIN),
    .PULSE_MAX(WMAX), .SCALE_SHIFT(SHIFT), .POS_LIMIT(LIM), .SLEW_MAX(SLEW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  int assert_cnt = 0;
  int fail_cnt   = 0;

  task automatic chk(string name, longint act, longint exp);
    assert_cnt++;
    if (act != exp) begin
      fail_cnt++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic longint fb(int i);
    return longint'($signed(bus_if.jointFeedback[32*i +: 32]));
  endfunction

  // ---------------- reference model (state after the latest clock edge) ----------
  int m_fb[NCH], m_cnt[NCH], m_ph[NCH], m_w[NCH], m_en[NCH], m_pwm[NCH];
  int m_fcnt = 0;
  int m_fs = 0;
  bit m_known = 1'b0;
  bit p_valid = 1'b0;
  bit p_rst;
  bit [NCH-1:0] p_en;
  int p_cmd[NCH];

  function automatic int width_target(int f);
    int raw;
    raw = CTR + (f >>> SHIFT);
    if (raw < WMIN) return WMIN;
    if (raw > WMAX) return WMAX;
    return raw;
  endfunction

  task automatic model_edge(bit r, bit [NCH-1:0] en, int c0, int c1);
    int cmd, tgt, d;
    longint mag, half;
    if (r) begin
      m_fcnt = 0; m_fs = 0; m_known = 1'b1;
      for (int i = 0; i < NCH; i++) begin
        m_fb[i] = 0; m_cnt[i] = 0; m_ph[i] = 0; m_w[i] = CTR; m_en[i] = 0; m_pwm[i] = 0;
      end
      return;
    end
    for (int i = 0; i < NCH; i++) begin
      cmd = (i == 0) ? c0 : c1;
      m_pwm[i] = (m_en[i] != 0 && m_fcnt < m_w[i]) ? 1 : 0;
      if (m_fcnt == P - 1) begin
        tgt = width_target(m_fb[i]);
`ifdef RCSERVO_SLEW_EN
        d = tgt - m_w[i];
        if (d > SLEW) d = SLEW;
        if (d < -SLEW) d = -SLEW;
        m_w[i] = m_w[i] + d;
`else
        d = 0;
        m_w[i] = tgt + d;
`endif
        m_en[i] = int'(en[i]);
      end
      if (en[i] && cmd != 0) begin
        mag = (cmd < 0) ? -longint'(cmd) : longint'(cmd);
        if (mag > 64'h7FFF_FFFF) mag = 64'h7FFF_FFFF;
        half = mag >> 1;
        if (longint'(m_cnt[i]) >= half) begin
          m_cnt[i] = 0;
          if (m_ph[i] != 0) begin
            if (cmd > 0 && m_fb[i] < LIM) m_fb[i]++;
            else if (cmd < 0 && m_fb[i] > -LIM) m_fb[i]--;
          end
          m_ph[i] = 1 - m_ph[i];
        end else begin
          m_cnt[i]++;
        end
      end
    end
    m_fs   = (m_fcnt == 0) ? 1 : 0;
    m_fcnt = (m_fcnt + 1) % P;
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (p_valid) model_edge(p_rst, p_en, p_cmd[0], p_cmd[1]);
    if (m_known) begin
      chk("cyc_frame_start", bus_if.frame_start, m_fs);
      chk("cyc_pwm0", bus_if.PWM[0], m_pwm[0]);
      chk("cyc_pwm1", bus_if.PWM[1], m_pwm[1]);
      chk("cyc_fb0", fb(0), m_fb[0]);
      chk("cyc_fb1", fb(1), m_fb[1]);
    end
    p_rst    = rst;
    p_en     = bus_if.enable;
    p_cmd[0] = $signed(bus_if.jointFreqCmd[31:0]);
    p_cmd[1] = $signed(bus_if.jointFreqCmd[63:32]);
    p_valid  = 1'b1;
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_fs();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2 * P; i++) begin
      @(negedge clk);
      if (bus_if.frame_start) begin
        seen = 1'b1;
        break;
      end
    end
    chk("frame_start_timeout", seen, 1);
  endtask

  // Starts on a negedge showing frame_start; ends on the next frame's frame_start negedge.
  task automatic measure(output int h0, output int h1);
    int fs_seen;
    h0 = 0; h1 = 0; fs_seen = 0;
    for (int i = 0; i < P; i++) begin
      h0 += int'(bus_if.PWM[0]);
      h1 += int'(bus_if.PWM[1]);
      fs_seen += int'(bus_if.frame_start);
      @(negedge clk);
    end
    chk("frame_start_once", fs_seen, 1);
    chk("frame_period", bus_if.frame_start, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0, h1;
    int exp_w0[4];
`ifdef RCSERVO_SLEW_EN
    exp_w0 = '{160, 165, 170, 175};
`else
    exp_w0 = '{175, 175, 175, 175};
`endif
    bus_if.enable       = 2'b11;
    bus_if.jointFreqCmd = '0;

    // Reset and idle frames.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_fb0", fb(0), 0);
    chk("reset_fb1", fb(1), 0);
    chk("reset_pwm", bus_if.PWM, 0);
    chk("reset_frame_start", bus_if.frame_start, 0);
    wait_fs();
    measure(h0, h1);
    chk("idle_first_frame_w0", h0, 0);
    chk("idle_first_frame_w1", h1, 0);
    measure(h0, h1);
    chk("idle_w0", h0, 150);
    chk("idle_w1", h1, 150);
    chk("idle_fb0", fb(0), 0);

    // Positive stepping: +10 gives one step every 12 cycles.
    @(posedge clk);
    #1 bus_if.jointFreqCmd[31:0] = 32'd10;
    repeat (1199) @(posedge clk);
    @(negedge clk);
    chk("pos_fb0_1199", fb(0), 99);
    @(posedge clk);
    #1 bus_if.jointFreqCmd[31:0] = 32'd0;
    @(negedge clk);
    chk("pos_fb0_1200", fb(0), 100);
    chk("pos_fb1", fb(1), 0);
    wait_fs();
    for (int k = 0; k < 4; k++) begin
      measure(h0, h1);
      chk("pos_width0", h0, exp_w0[k]);
      chk("pos_width1", h1, 150);
    end

    // Negative command saturates at -LIM and the width clamps to PULSE_MIN.
    @(posedge clk);
    #1 bus_if.jointFreqCmd[63:32] = 32'hFFFF_FFFC;
    repeat (6000) @(posedge clk);
    @(negedge clk);
    chk("neg_fb1_sat", fb(1), -1000);
    repeat (600) @(posedge clk);
    @(negedge clk);
    chk("neg_fb1_hold", fb(1), -1000);
    chk("neg_fb0", fb(0), 100);
    repeat (6) wait_fs();
    measure(h0, h1);
    chk("neg_width1", h1, 100);
    chk("neg_width0", h0, 175);

    // Frame atomicity: mid-pulse changes only apply from the next frame.
    fork
      measure(h0, h1);
      begin
        repeat (50) @(posedge clk);
        #1;
        bus_if.enable[1]            = 1'b0;
        bus_if.jointFreqCmd[31:0]   = -32'sd10;
      end
    join
    chk("atom_width0", h0, 175);
    chk("atom_width1", h1, 100);
    measure(h0, h1);
    chk("atom_next_width1", h1, 0);
    @(posedge clk);
    #1 bus_if.enable[0] = 1'b0;
    wait_fs();
    measure(h0, h1);
    chk("disable_width0", h0, 0);

    // Reset mid-frame at frame_cnt = 400 with feedback0 = 77.
    @(posedge clk);
    #1;
    bus_if.enable       = 2'b11;
    bus_if.jointFreqCmd = '0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (476) @(posedge clk);
    #1 bus_if.jointFreqCmd[31:0] = 32'd10;
    repeat (924) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_fb0_before", fb(0), 77);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_fb0", fb(0), 0);
    chk("midrst_pwm", bus_if.PWM, 0);
    chk("midrst_frame_start", bus_if.frame_start, 0);
    @(negedge clk);
    chk("midrst_restart_frame_start", bus_if.frame_start, 1);
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end
endmodule

// File: doc/rcservo_multi.md
Name: rcservo_multi

Overview:
- Multi-channel RC servo driver, the parametrised successor of the single-channel servo joint.
- Each channel integrates a signed step-frequency command into a position counter, which is reported back as joint feedback.
- Position maps to a pulse width, clamped to safe limits and latched once per frame.
- All channels share one frame counter, so their pulses start on the same cycle.

Parameters:
- NUM_CH, 4, number of servo channels.
- SERVO_PERIOD, 480000, frame length in clk cycles (10 ms at 48 MHz).
- SERVO_CENTER, 72000, pulse width in clk cycles at feedback 0 (1.5 ms).
- PULSE_MIN, 48000, minimum pulse width in clk cycles (1.0 ms).
- PULSE_MAX, 96000, maximum pulse width in clk cycles (2.0 ms).
- SCALE_SHIFT, 6, pulse offset = feedback >>> SCALE_SHIFT.
- POS_LIMIT, 2000000, feedback saturates at ±POS_LIMIT.
- SLEW_MAX, 200, maximum width change per frame in clk cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  NUM_CH  per-channel enable.
- jointFreqCmd  in  32*NUM_CH  packed signed commands; channel i occupies bits [32i+31:32i].
- jointFeedback  out  32*NUM_CH  packed signed position counters.
- PWM  out  NUM_CH  servo pulse outputs.
- frame_start  out  1  one-cycle pulse at frame counter 0.

Behaviour:
- Reset, synchronous: on the clk edge with rst=1, clear everything below. Outputs are 0 from the following cycle.
  - Cleared: frame counter, all step counters, phases and feedback; PWM=0; frame_start=0.
  - Latched widths are set to SERVO_CENTER and latched enables to 0.
  - rst mid-frame aborts the frame.
  - The first cycle after rst deasserts is frame counter 0.
- Step generator, per channel:
  - abs = |cmd| >> 1. For cmd = 0x80000000, |cmd| saturates to 0x7FFFFFFF before the shift.
  - If enable[i]=0 or cmd=0: step counter and phase hold; feedback holds.
  - Otherwise the step counter increments each cycle. When counter >= abs: counter <= 0 and phase toggles.
  - On a toggle where the old phase is 1, feedback moves ±1 according to the sign of cmd.
  - Step period = 2*(abs+1) cycles.
  - Feedback saturates: a step that would exceed ±POS_LIMIT is dropped; phase still toggles.
  - A command change mid-count takes effect on the next compare. The counter is not reset.
- Width computation, per channel, combinational from current feedback:
  - raw = SERVO_CENTER + (feedback >>> SCALE_SHIFT), using 33-bit signed arithmetic.
  - target = clamp(raw, PULSE_MIN, PULSE_MAX).
- Frame:
  - frame_cnt runs 0..SERVO_PERIOD-1 and wraps to 0.
  - frame_start = 1 while frame_cnt == 0.
  - On the cycle frame_cnt == SERVO_PERIOD-1: width_lat[i] <= target[i] and en_lat[i] <= enable[i].
  - Mid-frame changes to feedback or enable never alter the current pulse.
- Output, registered, 1-cycle latency from frame_cnt:
  - PWM[i] = en_lat[i] && (frame_cnt < width_lat[i]).
  - High time is exactly width_lat cycles; rising edge is coincident with frame_start.
- Required constraint: PULSE_MIN <= SERVO_CENTER <= PULSE_MAX < SERVO_PERIOD.

Optional Feature:
- Macro: RCSERVO_SLEW_EN.
- Defined: at each frame latch, width_lat moves toward target by at most SLEW_MAX, i.e. width_lat += clamp(target - width_lat, -SLEW_MAX, +SLEW_MAX). Reset still loads SERVO_CENTER. Feedback is unaffected.
- Undefined: width_lat <= target directly. The SLEW_MAX parameter is unused.

Test Plan:
Bench parameters: NUM_CH=2, SERVO_PERIOD=1000, SERVO_CENTER=150, PULSE_MIN=100, PULSE_MAX=200, SCALE_SHIFT=2, POS_LIMIT=1000, SLEW_MAX=5.
- Idle frames: rst 1 cycle, enable=2'b11, cmd=0 -> PWM[1:0] high 0 in first frame (en_lat=0). From the second frame: high exactly 150 cycles every 1000; frame_start every 1000 cycles; feedback stays 0.
- Positive steps: cmd0=+10 applied at a frame boundary -> step every 12 cycles; feedback0 = 100 after 1200 cycles. The next latched width is 175, giving a 175-cycle pulse. Channel 1 is unaffected.
- Negative saturation: cmd1=-4 -> step every 6 cycles. Feedback1 saturates at -1000 and holds. Width clamps to 100, since raw = 150-250.
- Frame atomicity: change cmd or enable mid-pulse -> the current pulse width and level are unchanged; the new value applies from the next frame_start. Enable=0 -> feedback frozen immediately, PWM low from the next frame.
- Reset mid-operation: rst asserted 1 cycle at frame_cnt=400 with feedback0=77 -> next cycle feedback0=0 and PWM=0; frame_cnt restarts at 0 after rst deasserts.
- Slew (RCSERVO_SLEW_EN): target jumps 150->175 -> latched widths over frames are 155, 160, 165, 170, 175. Without the macro the width is 175 immediately.
